// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
package icache_pkg;
  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int LINES   = 8;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;
endpackage

// File: rtl/icache_if.sv
// CPU fetch port plus block-memory port plus perf counters of the icache.
interface icache_if #(parameter int CNT_W = 16);
  logic [31:0]      PC;
  logic [31:0]      INSTRUCTION;
  logic             BUSYWAIT;
  logic             MEM_READ;
  logic [5:0]       MEM_ADDRESS;
  logic [127:0]     MEM_READDATA;
  logic             MEM_BUSYWAIT;
  logic [CNT_W-1:0] HIT_COUNT;
  logic [CNT_W-1:0] MISS_COUNT;

  modport slave (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, HIT_COUNT, MISS_COUNT
  );
  modport master (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, HIT_COUNT, MISS_COUNT
  );
endinterface

// File: rtl/icache_store.sv
// Valid/tag/data arrays: synchronous fill and valid clear, combinational lookup.
module icache_store
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IDX_W-1:0]   idx,
  input  logic [TAG_W-1:0]   tag,
  input  logic [OFF_W-1:0]   off,
  input  logic [BLOCK_W-1:0] wdata,
  output logic               hit,
  output logic [31:0]        word
);
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tags [LINES];
  logic [BLOCK_W-1:0] data [LINES];

  always_ff @(posedge clk) begin
    if (rst)     valid      <= '0;
    else if (we) valid[idx] <= 1'b1;
  end

  // Tags and data are left untouched by reset; valid alone gates hits.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[idx] <= tag;
      data[idx] <= wdata;
    end
  end

  assign hit  = valid[idx] && (tags[idx] == tag);
  assign word = data[idx][{off, 5'd0} +: 32];
endmodule

// File: rtl/icache_controller.sv
// Direct-mapped icache: zero-latency hits, blocking line fill on miss, saturating perf counters.
module icache_controller
  import icache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic   CLK,
  input  logic   RESET,
  icache_if.slave bus
);
  state_t           state;
  logic             stall_q;
  logic             mem_read_q;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             hit;
  logic             fill;
  logic [31:0]      word;

  // Index/tag come live from PC; the CPU holds PC stable while stalled.
  assign fill = (state == MEM_READ) && !bus.MEM_BUSYWAIT && !RESET;

  icache_store u_store (
    .clk   (CLK),
    .rst   (RESET),
    .we    (fill),
    .idx   (bus.PC[6:4]),
    .tag   (bus.PC[9:7]),
    .off   (bus.PC[3:2]),
    .wdata (bus.MEM_READDATA),
    .hit   (hit),
    .word  (word)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      stall_q    <= 1'b0;
      mem_read_q <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            state      <= MEM_READ;
            stall_q    <= 1'b1;
            mem_read_q <= 1'b1;
          end
        end
        MEM_READ: begin
          if (!bus.MEM_BUSYWAIT) begin
            state      <= UPDATE;
            mem_read_q <= 1'b0;
          end
        end
        UPDATE: begin
          state   <= IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          stall_q    <= 1'b0;
          mem_read_q <= 1'b0;
        end
      endcase
    end
  end

  // Reset overrides combinationally so an in-flight request drops immediately.
  assign bus.BUSYWAIT    = RESET || stall_q || !hit;
  assign bus.MEM_READ    = !RESET && mem_read_q;
  assign bus.MEM_ADDRESS = bus.PC[9:4];
  assign bus.INSTRUCTION = word;
  assign bus.HIT_COUNT   = hit_cnt;
  assign bus.MISS_COUNT  = miss_cnt;
endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a latency-programmable block memory model.
module tb_icache_controller;
  logic CLK = 1'b0;
  logic RESET;
  logic rst2;
  int   total = 0;
  int   bad   = 0;
  int   lat   = 5;
  int   lat_cnt = 0;
  logic [31:0] exp_q [$];

  always #5 CLK = ~CLK;

  icache_if #(.CNT_W(16)) bus ();
  icache_if #(.CNT_W(4))  bus2 ();

  icache_controller #(.CNT_W(16)) dut  (.CLK(CLK), .RESET(RESET), .bus(bus));
  icache_controller #(.CNT_W(4))  dut2 (.CLK(CLK), .RESET(rst2),  .bus(bus2));

  function automatic logic [31:0] wd(input logic [5:0] b, input logic [1:0] w);
    if (b == 6'd0) return 32'h11111111 * (32'(w) + 32'd1);
    return {16'hC0DE, 2'b00, b, 6'b000000, w};
  endfunction

  function automatic logic [127:0] blk(input logic [5:0] b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[32*w +: 32] = wd(b, 2'(w));
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return wd(pc[9:4], pc[3:2]);
  endfunction

  // Memory holds MEM_BUSYWAIT high for `lat` cycles of an active request.
  always_comb begin
    bus.MEM_BUSYWAIT  = bus.MEM_READ && (lat_cnt < lat);
    bus.MEM_READDATA  = blk(bus.MEM_ADDRESS);
    bus2.MEM_BUSYWAIT = 1'b0;
    bus2.MEM_READDATA = blk(bus2.MEM_ADDRESS);
  end

  always @(posedge CLK) lat_cnt <= bus.MEM_READ ? lat_cnt + 1 : 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a PC, wait for the stall to clear, check latency/data, then consume it.
  task automatic fetch(input logic [31:0] pc, input int exp_pen, input string tag);
    int n, mr;
    logic [5:0] addr;
    logic seen;
    exp_q.push_back(word_of(pc));
    bus.PC = pc;
    #1;
    n = 0; mr = 0; seen = 1'b0; addr = '0;
    while (bus.BUSYWAIT !== 1'b0 && n < 60) begin
      if (bus.MEM_READ === 1'b1) begin
        mr++;
        if (!seen) begin addr = bus.MEM_ADDRESS; seen = 1'b1; end
      end
      tick();
      n++;
    end
    chk({tag, ".penalty"}, 32'(n), 32'(exp_pen));
    chk({tag, ".inst"}, bus.INSTRUCTION, exp_q.pop_front());
    if (exp_pen > 0) begin
      chk({tag, ".memread_cycles"}, 32'(mr), 32'(lat + 1));
      chk({tag, ".mem_addr"}, 32'(addr), 32'(pc[9:4]));
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    RESET = 1'b1; rst2 = 1'b1;
    bus.PC = 32'h0; bus2.PC = 32'h20;
    tick();
    chk("rst.busywait", 32'(bus.BUSYWAIT), 32'd1);
    chk("rst.mem_read", 32'(bus.MEM_READ), 32'd0);
    chk("rst.hit", 32'(bus.HIT_COUNT), 32'd0);
    chk("rst.miss", 32'(bus.MISS_COUNT), 32'd0);
    tick();

    // Cold start, latency 5: 8-edge penalty.
    RESET = 1'b0;
    #1;
    chk("cold.first_busy", 32'(bus.BUSYWAIT), 32'd1);
    fetch(32'h0, 8, "cold");
    chk("cold.hit", 32'(bus.HIT_COUNT), 32'd1);
    chk("cold.miss", 32'(bus.MISS_COUNT), 32'd1);

    fetch(32'h4, 0, "spat4");
    fetch(32'h8, 0, "spat8");
    fetch(32'hC, 0, "spat12");
    chk("spat.hit", 32'(bus.HIT_COUNT), 32'd4);
    chk("spat.miss", 32'(bus.MISS_COUNT), 32'd1);

    // Conflict eviction on index 0, latency 2.
    RESET = 1'b1; lat = 2;
    tick();
    RESET = 1'b0;
    fetch(32'h000, 5, "conf0");
    fetch(32'h080, 5, "conf80");
    fetch(32'h000, 5, "conf0b");
    chk("conf.hit", 32'(bus.HIT_COUNT), 32'd3);
    chk("conf.miss", 32'(bus.MISS_COUNT), 32'd3);

    // Reset on the 3rd MEM_READ cycle of a fill.
    lat = 5;
    bus.PC = 32'h40;
    tick();
    chk("midrst.mr1", 32'(bus.MEM_READ), 32'd1);
    tick();
    tick();
    chk("midrst.mr3", 32'(bus.MEM_READ), 32'd1);
    RESET = 1'b1;
    #1;
    chk("midrst.mr_drop", 32'(bus.MEM_READ), 32'd0);
    chk("midrst.busy", 32'(bus.BUSYWAIT), 32'd1);
    tick();
    chk("midrst.hit", 32'(bus.HIT_COUNT), 32'd0);
    chk("midrst.miss", 32'(bus.MISS_COUNT), 32'd0);
    RESET = 1'b0;
    fetch(32'h40, 8, "refetch40");
    chk("refetch.miss", 32'(bus.MISS_COUNT), 32'd1);

    // Zero-latency memory and address aliasing.
    lat = 0;
    fetch(32'h400, 3, "alias400");
    fetch(32'h000, 0, "alias000");
    chk("alias.hit", 32'(bus.HIT_COUNT), 32'd3);
    chk("alias.miss", 32'(bus.MISS_COUNT), 32'd2);

    // Saturation on the 4-bit-counter instance.
    rst2 = 1'b0;
    #1;
    n = 0;
    while (bus2.BUSYWAIT !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    chk("sat.penalty", 32'(n), 32'd3);
    chk("sat.inst", bus2.INSTRUCTION, word_of(32'h20));
    for (int i = 0; i < 20; i++) tick();
    chk("sat.hit", 32'(bus2.HIT_COUNT), 32'd15);
    chk("sat.miss", 32'(bus2.MISS_COUNT), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
